// File: rtl/radiant_event_reader_pkg.sv
// Shared constants and state encoding for the radiant event header reader.
// No logic; constants only.
// Imported by radiant_event_reader and its bench.
package radiant_event_reader_pkg;

   // "RDE0": the first dword of every valid event header
   localparam logic [31:0] EVENT_IDENTIFIER = 32'h52444530;
   localparam int          NUM_EVENT_DWORDS = 8;
   localparam logic [8:0]  HDR_BASE_ADR     = 9'h100;
   localparam int          HDR_TIMEOUT      = 255;
   localparam int          HDR_MAX_PENDING  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_PUSH  = 2'd2,
      ST_ABORT = 2'd3
   } state_t;

endpackage

// File: rtl/radiant_event_reader.sv
// Reads NUM_DWORDS-dword event headers over Wishbone and streams them out one dword at a time.
// Latency: ack -> m_tvalid 1 cycle, transfer -> next stb 1 cycle; one bus read in flight at most.
// Backpressure: m_tready low holds the captured dword and stalls the next bus read (no skid buffer).
module radiant_event_reader
   import radiant_event_reader_pkg::*;
#(
   parameter logic [8:0] BASE_ADR    = HDR_BASE_ADR,
   parameter int         NUM_DWORDS  = NUM_EVENT_DWORDS,
   parameter int         TIMEOUT     = HDR_TIMEOUT,
   parameter int         MAX_PENDING = HDR_MAX_PENDING
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // Wishbone master
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic [8:0]  wb_adr_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_rty_i,
   // control
   input  logic        enable_i,
   input  logic        event_pending_i,
   input  logic        clear_i,
   // stream out
   output logic [31:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   // status
   output logic [4:0]  pending_o,
   output logic [15:0] events_done_o,
   output logic        id_err_o,
   output logic        bus_err_o,
   output logic        ovf_err_o
);

   localparam int IDX_W = (NUM_DWORDS > 1) ? $clog2(NUM_DWORDS) : 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [31:0]       dat_q, dat_d;
   logic [4:0]        pend_q, pend_d;
   logic [15:0]       done_q, done_d;
   logic              id_err_q, id_err_d;
   logic              bus_err_q, bus_err_d;
   logic              ovf_err_q, ovf_err_d;

   logic              start;
   logic              last_idx;
   logic              new_id_err, new_bus_err, new_ovf_err;

   // Next-state, pending counter and sticky error flags
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      tmo_d       = '0;
      dat_d       = dat_q;
      pend_d      = pend_q;
      done_d      = done_q;
      new_id_err  = 1'b0;
      new_bus_err = 1'b0;
      new_ovf_err = 1'b0;

      start    = (state_q == ST_IDLE) && enable_i && (pend_q != 5'd0);
      last_idx = (idx_q == IDX_W'(NUM_DWORDS - 1));

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_READ;
               idx_d   = '0;
            end
         end
         ST_READ: begin
            if (wb_err_i || wb_rty_i) begin
               state_d     = ST_ABORT;
               new_bus_err = 1'b1;
            end else if (wb_ack_i) begin
               dat_d   = wb_dat_i;
               state_d = ST_PUSH;
               // a bad identifier is flagged but the header is still drained
               if ((idx_q == '0) && (wb_dat_i != EVENT_IDENTIFIER)) new_id_err = 1'b1;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               state_d     = ST_ABORT;
               new_bus_err = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_PUSH: begin
            if (m_tready) begin
               if (last_idx) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  done_d  = done_q + 16'd1;
               end else begin
                  state_d = ST_READ;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            // ST_ABORT: parked until software acknowledges the bus error
            if (clear_i) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end
         end
      endcase

      // an arrival and a header start in the same cycle cancel out
      if (event_pending_i && !start) begin
         if (pend_q == 5'(MAX_PENDING)) new_ovf_err = 1'b1;
         else                           pend_d      = pend_q + 5'd1;
      end else if (!event_pending_i && start) begin
         pend_d = pend_q - 5'd1;
      end

      // clear loses against an error raised in the same cycle
      id_err_d  = (id_err_q  && !clear_i) || new_id_err;
      bus_err_d = (bus_err_q && !clear_i) || new_bus_err;
      ovf_err_d = (ovf_err_q && !clear_i) || new_ovf_err;
   end

   // State and datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         tmo_q     <= '0;
         dat_q     <= '0;
         pend_q    <= '0;
         done_q    <= '0;
         id_err_q  <= 1'b0;
         bus_err_q <= 1'b0;
         ovf_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         tmo_q     <= tmo_d;
         dat_q     <= dat_d;
         pend_q    <= pend_d;
         done_q    <= done_d;
         id_err_q  <= id_err_d;
         bus_err_q <= bus_err_d;
         ovf_err_q <= ovf_err_d;
      end
   end

   // Outputs decoded straight from state so reset drops the bus at once
   always_comb begin
      wb_cyc_o      = (state_q == ST_READ);
      wb_stb_o      = (state_q == ST_READ);
      wb_we_o       = 1'b0;
      wb_sel_o      = 4'hF;
      wb_adr_o      = BASE_ADR + {{(9 - IDX_W - 2){1'b0}}, idx_q, 2'b00};
      m_tvalid      = (state_q == ST_PUSH);
      m_tlast       = (state_q == ST_PUSH) && last_idx;
      m_tdata       = dat_q;
      pending_o     = pend_q;
      events_done_o = done_q;
      id_err_o      = id_err_q;
      bus_err_o     = bus_err_q;
      ovf_err_o     = ovf_err_q;
   end

endmodule
